// File: rtl/snake_pkg.sv
// Shared types and constants for the snake input conditioner: direction
// encoding, speed width and the reversal test used by the direction filter.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  localparam dir_e DIR_RESET = DIR_RIGHT;

  localparam int SPEED_W    = 2;
  localparam int TICK_CNT_W = 26;

  // Same axis, opposite sense: the snake would turn back into its own body.
  function automatic logic is_reversal(input dir_e req, input dir_e ref_dir);
    logic [1:0] r;
    logic [1:0] c;
    r = req;
    c = ref_dir;
    return (r[1] == c[1]) && (r[0] != c[0]);
  endfunction

endpackage

// File: rtl/snake_input_conditioner_if.sv
// Link between the input conditioner and the game core: run/new_game come
// from the core, direction, step tick, start pulse and speed go back to it.
interface snake_input_conditioner_if;
  import snake_pkg::*;

  logic               run;
  logic               new_game;
  dir_e               dir;
  logic               game_tick;
  logic               start_pulse;
  logic [SPEED_W-1:0] speed;

  modport master (input  run, new_game,
                  output dir, game_tick, start_pulse, speed);

  modport slave  (output run, new_game,
                  input  dir, game_tick, start_pulse, speed);

endinterface

// File: rtl/debounce_cell.sv
// Two-flop synchronizer plus stability-window debouncer for one raw input;
// emits the debounced level and registered one-cycle rise/fall pulses.
module debounce_cell #(
  parameter int   CYCLES    = 4,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic clrn,
  input  logic din,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = (CYCLES < 2) ? 1 : $clog2(CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every output of this block gets a default before any branch, so no path can leave a value held and infer a latch.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_W'(CYCLES - 1)) begin
        stable_d = sync2_q;
        rise_d   = sync2_q;
        fall_d   = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: non-blocking assignments make all flops sample pre-edge values, which the synchronizer chain depends on.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      sync1_q  <= RESET_VAL;
      sync2_q  <= RESET_VAL;
      stable_q <= RESET_VAL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= din;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign rise   = rise_q;
  assign fall   = fall_q;

endmodule

// File: rtl/snake_input_conditioner.sv
// Front end of the snake game: debounces board inputs, filters direction
// reversals, tracks encoder speed and generates the game step tick.
module snake_input_conditioner
  import snake_pkg::*;
#(
  parameter int DEB_CYCLES     = 1000000,
  parameter int ENC_DEB_CYCLES = 50000,
  parameter int TICK_DIV0      = 50000000,
  parameter int TICK_DIV1      = 40000000,
  parameter int TICK_DIV2      = 20000000,
  parameter int TICK_DIV3      = 10000000
) (
  input  logic clk,
  input  logic clrn,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_start,
  input  logic enc_a,
  input  logic enc_b,
  input  logic enc_sw,
  snake_input_conditioner_if.master core
);

  localparam int N_BTN = 5;
  localparam logic [SPEED_W-1:0] SPEED_MAX = '1;

  // Bit order: 0 up, 1 down, 2 left, 3 right, 4 start.
  logic [N_BTN-1:0] btn_raw, btn_stable, btn_rise, btn_fall;
  logic a_stable, a_rise, a_fall;
  logic b_stable, b_rise, b_fall;
  logic sw_stable, sw_rise, sw_fall;

  assign btn_raw = {btn_start, btn_right, btn_left, btn_down, btn_up};

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    debounce_cell #(.CYCLES(DEB_CYCLES), .RESET_VAL(1'b0)) u_deb (
      .clk(clk), .clrn(clrn), .din(btn_raw[i]),
      .stable(btn_stable[i]), .rise(btn_rise[i]), .fall(btn_fall[i])
    );
  end

  debounce_cell #(.CYCLES(ENC_DEB_CYCLES), .RESET_VAL(1'b0)) u_enc_a (
    .clk(clk), .clrn(clrn), .din(enc_a),
    .stable(a_stable), .rise(a_rise), .fall(a_fall)
  );
  debounce_cell #(.CYCLES(ENC_DEB_CYCLES), .RESET_VAL(1'b0)) u_enc_b (
    .clk(clk), .clrn(clrn), .din(enc_b),
    .stable(b_stable), .rise(b_rise), .fall(b_fall)
  );
  debounce_cell #(.CYCLES(ENC_DEB_CYCLES), .RESET_VAL(1'b1)) u_enc_sw (
    .clk(clk), .clrn(clrn), .din(enc_sw),
    .stable(sw_stable), .rise(sw_rise), .fall(sw_fall)
  );

  logic unused_sigs;
  assign unused_sigs = ^{btn_stable, btn_fall, a_stable, a_fall,
                         b_rise, b_fall, sw_stable, sw_rise};

  dir_e                  dir_q, dir_d, pending_q, pending_d, req, ref_dir;
  logic                  req_valid;
  logic [SPEED_W-1:0]    speed_q, speed_d;
  logic [TICK_CNT_W-1:0] tick_cnt_q, tick_cnt_d, tick_last;
  logic                  game_tick_q, game_tick_d;
  logic                  start_pulse_q, start_pulse_d;

  always_comb begin
    req_valid = |btn_rise[3:0];
    req       = DIR_UP;
    if      (btn_rise[0]) req = DIR_UP;
    else if (btn_rise[1]) req = DIR_DOWN;
    else if (btn_rise[2]) req = DIR_LEFT;
    else if (btn_rise[3]) req = DIR_RIGHT;
  end

  // A push-button press resets speed even if a detent lands on the same cycle.
  always_comb begin
    speed_d = speed_q;
    if (sw_fall) begin
      speed_d = '0;
    end else if (a_rise) begin
      if (!b_stable) begin
        if (speed_q != SPEED_MAX) speed_d = speed_q + 1'b1;
      end else if (speed_q != '0) begin
        speed_d = speed_q - 1'b1;
      end
    end
  end

  always_comb begin
    tick_last = TICK_CNT_W'(TICK_DIV0 - 1);
    case (speed_q)
      2'd0: tick_last = TICK_CNT_W'(TICK_DIV0 - 1);
      2'd1: tick_last = TICK_CNT_W'(TICK_DIV1 - 1);
      2'd2: tick_last = TICK_CNT_W'(TICK_DIV2 - 1);
      2'd3: tick_last = TICK_CNT_W'(TICK_DIV3 - 1);
      default: ;
    endcase
  end

  // The reversal check uses the direction dir will hold after this edge.
  always_comb begin
    tick_cnt_d    = tick_cnt_q + 1'b1;
    game_tick_d   = 1'b0;
    dir_d         = dir_q;
    pending_d     = pending_q;
    start_pulse_d = btn_rise[4];

    if (!core.run || core.new_game || (speed_d != speed_q)) begin
      tick_cnt_d = '0;
    end else if (tick_cnt_q == tick_last) begin
      tick_cnt_d  = '0;
      game_tick_d = 1'b1;
    end

    ref_dir = game_tick_d ? pending_q : dir_q;
    if (req_valid && !is_reversal(req, ref_dir)) pending_d = req;
    if (game_tick_d) dir_d = pending_q;

    if (core.new_game) begin
      dir_d     = DIR_RESET;
      pending_d = DIR_RESET;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      dir_q         <= DIR_RESET;
      pending_q     <= DIR_RESET;
      speed_q       <= '0;
      tick_cnt_q    <= '0;
      game_tick_q   <= 1'b0;
      start_pulse_q <= 1'b0;
    end else begin
      dir_q         <= dir_d;
      pending_q     <= pending_d;
      speed_q       <= speed_d;
      tick_cnt_q    <= tick_cnt_d;
      game_tick_q   <= game_tick_d;
      start_pulse_q <= start_pulse_d;
    end
  end

  assign core.dir         = dir_q;
  assign core.game_tick   = game_tick_q;
  assign core.start_pulse = start_pulse_q;
  assign core.speed       = speed_q;

endmodule

// File: tb/tb_snake_input_conditioner.sv
// Self-checking bench for snake_input_conditioner with short debounce and
// tick periods; expected game ticks are queued and checked as they arrive.
module tb_snake_input_conditioner;
  import snake_pkg::*;

  localparam int DEB = 4;
  localparam int ENC = 2;
  localparam int DIV0 = 40, DIV1 = 32, DIV2 = 16, DIV3 = 8;

  logic       clk = 1'b0;
  logic       clrn;
  logic [4:0] btn;
  logic       enc_a, enc_b, enc_sw;

  snake_input_conditioner_if core_if ();

  snake_input_conditioner #(
    .DEB_CYCLES(DEB), .ENC_DEB_CYCLES(ENC),
    .TICK_DIV0(DIV0), .TICK_DIV1(DIV1), .TICK_DIV2(DIV2), .TICK_DIV3(DIV3)
  ) dut (
    .clk(clk), .clrn(clrn),
    .btn_up(btn[0]), .btn_down(btn[1]), .btn_left(btn[2]), .btn_right(btn[3]),
    .btn_start(btn[4]),
    .enc_a(enc_a), .enc_b(enc_b), .enc_sw(enc_sw),
    .core(core_if.master)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int start_cnt = 0;
  int last_start = 0;
  int tick_total = 0;
  int prev_tick = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (core_if.start_pulse) begin
      start_cnt  <= start_cnt + 1;
      last_start <= cyc;
    end
    if (core_if.game_tick) tick_total <= tick_total + 1;
  end

  // gap == 0: only the direction is checked; from < 0: gap counts from the previous tick.
  typedef struct {
    string      tag;
    logic [1:0] dir;
    int         gap;
    int         from;
  } tick_exp_t;

  tick_exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_tick(input string tag, input logic [1:0] d, input int gap, input int from);
    tick_exp_t e;
    e.tag = tag; e.dir = d; e.gap = gap; e.from = from;
    sb.push_back(e);
  endtask

  task automatic drain_ticks(input int budget);
    tick_exp_t e;
    int w;
    int base;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      w = 0;
      do begin
        step(1);
        w++;
      end while (!core_if.game_tick && w < budget);
      if (!core_if.game_tick) begin
        check({e.tag, "_timeout"}, 32'd0, 32'd1);
      end else begin
        check({e.tag, "_dir"}, 32'(core_if.dir), 32'(e.dir));
        if (e.gap != 0) begin
          base = (e.from < 0) ? prev_tick : e.from;
          check({e.tag, "_gap"}, 32'(cyc - base), 32'(e.gap));
        end
        prev_tick = cyc;
      end
    end
  endtask

  task automatic press(input int idx);
    btn[idx] = 1'b1;
    step(12);
    btn[idx] = 1'b0;
    step(12);
  endtask

  task automatic pulse_new_game();
    core_if.new_game = 1'b1;
    step(1);
    core_if.new_game = 1'b0;
  endtask

  task automatic detent(output int s);
    logic [1:0] old;
    int w;
    old = core_if.speed;
    w = 0;
    enc_a = 1'b1;
    do begin
      step(1);
      w++;
    end while (core_if.speed == old && w < 20);
    check("detent_speed_changed", 32'(core_if.speed != old), 32'd1);
    s = cyc;
    step(1);
    enc_a = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r, s, n, t_rise, snap;

    clrn = 1'b0;
    btn = '0;
    enc_a = 1'b0; enc_b = 1'b0; enc_sw = 1'b1;
    core_if.run = 1'b0;
    core_if.new_game = 1'b0;
    step(3);
    check("rst_dir", 32'(core_if.dir), 32'(DIR_RIGHT));
    check("rst_tick", 32'(core_if.game_tick), 32'd0);
    check("rst_start", 32'(core_if.start_pulse), 32'd0);
    check("rst_speed", 32'(core_if.speed), 32'd0);
    clrn = 1'b1;
    step(5);

    // Bounce on up and start, then a clean hold.
    for (int i = 0; i < 10; i++) begin
      btn[0] = ~btn[0];
      btn[4] = ~btn[4];
      step(2);
    end
    check("s1_no_pulse_bounce", 32'(start_cnt), 32'd0);
    btn[0] = 1'b1; btn[4] = 1'b1;
    t_rise = cyc;
    step(20);
    check("s1_one_pulse", 32'(start_cnt), 32'd1);
    check("s1_latency_7pm1", 32'((last_start - t_rise >= DEB + 2) && (last_start - t_rise <= DEB + 4)), 32'd1);
    btn = '0;
    step(12);
    core_if.run = 1'b1;
    r = cyc;
    push_tick("s1_pending_up", DIR_UP, DIV0, r);
    drain_ticks(100);
    core_if.run = 1'b0;

    // Reversal filtering.
    pulse_new_game();
    check("s2_newgame_dir", 32'(core_if.dir), 32'(DIR_RIGHT));
    snap = tick_total;
    press(2);
    check("s2_no_tick_run0", 32'(tick_total), 32'(snap));
    core_if.run = 1'b1;
    r = cyc;
    push_tick("s2_left_dropped", DIR_RIGHT, DIV0, r);
    drain_ticks(100);
    core_if.run = 1'b0;
    press(0);
    core_if.run = 1'b1;
    r = cyc;
    push_tick("s2_up", DIR_UP, DIV0, r);
    drain_ticks(100);
    core_if.run = 1'b0;
    press(1);
    core_if.run = 1'b1;
    r = cyc;
    push_tick("s2_down_dropped", DIR_UP, DIV0, r);
    drain_ticks(100);

    // Tick rate across speeds, with restart on every change.
    push_tick("s3_div0", DIR_UP, DIV0, -1);
    drain_ticks(100);
    detent(s);
    check("s3_speed1", 32'(core_if.speed), 32'd1);
    push_tick("s3_div1", DIR_UP, DIV1, s);
    drain_ticks(100);
    detent(s);
    check("s3_speed2", 32'(core_if.speed), 32'd2);
    push_tick("s3_div2", DIR_UP, DIV2, s);
    drain_ticks(100);
    detent(s);
    check("s3_speed3", 32'(core_if.speed), 32'd3);
    push_tick("s3_div3", DIR_UP, DIV3, s);
    push_tick("s3_div3_again", DIR_UP, DIV3, -1);
    drain_ticks(100);
    enc_a = 1'b1;
    step(10);
    check("s3_speed_sat", 32'(core_if.speed), 32'd3);
    enc_a = 1'b0;
    step(6);
    push_tick("s3_sat_sync", DIR_UP, 0, 0);
    push_tick("s3_sat_period", DIR_UP, DIV3, -1);
    drain_ticks(100);

    // Right press lands on the tick edge while pending=up, dir=right.
    core_if.run = 1'b0;
    pulse_new_game();
    check("s4_newgame_dir", 32'(core_if.dir), 32'(DIR_RIGHT));
    press(0);
    core_if.run = 1'b1;
    r = cyc;
    step(1);
    btn[3] = 1'b1;
    push_tick("s4_coinc_tick", DIR_UP, DIV3, r);
    push_tick("s4_right_commit", DIR_RIGHT, DIV3, -1);
    drain_ticks(100);
    btn[3] = 1'b0;
    core_if.run = 1'b0;
    step(10);

    // Encoder push beats a same-cycle CW detent.
    enc_b = 1'b1;
    step(6);
    detent(s);
    check("s5_ccw_speed2", 32'(core_if.speed), 32'd2);
    enc_b = 1'b0;
    step(6);
    enc_sw = 1'b0;
    enc_a = 1'b1;
    n = 0;
    do begin
      step(1);
      n++;
    end while (core_if.speed == 2'd2 && n < 20);
    check("s5_push_speed0", 32'(core_if.speed), 32'd0);
    step(8);
    check("s5_push_hold", 32'(core_if.speed), 32'd0);
    enc_sw = 1'b1;
    enc_a = 1'b0;
    step(8);

    // new_game mid-count with a pending left turn.
    press(0);
    core_if.run = 1'b1;
    r = cyc;
    push_tick("s6_up", DIR_UP, DIV0, r);
    drain_ticks(100);
    btn[2] = 1'b1;
    step(20);
    btn[2] = 1'b0;
    n = cyc;
    pulse_new_game();
    check("s6_newgame_dir", 32'(core_if.dir), 32'(DIR_RIGHT));
    push_tick("s6_newgame_tick", DIR_RIGHT, DIV0, n + 1);
    drain_ticks(100);

    // Asynchronous reset in the middle of a debounce window.
    detent(s);
    check("s6_speed1", 32'(core_if.speed), 32'd1);
    press(0);
    step(DIV1 + 4);
    check("s6_pre_reset_dir", 32'(core_if.dir), 32'(DIR_UP));
    snap = start_cnt;
    btn[4] = 1'b1;
    btn[0] = 1'b1;
    step(3);
    #2;
    clrn = 1'b0;
    #1;
    check("s6_async_dir", 32'(core_if.dir), 32'(DIR_RIGHT));
    check("s6_async_speed", 32'(core_if.speed), 32'd0);
    check("s6_async_tick", 32'(core_if.game_tick), 32'd0);
    check("s6_async_start", 32'(core_if.start_pulse), 32'd0);
    btn = '0;
    core_if.run = 1'b0;
    step(3);
    clrn = 1'b1;
    step(20);
    check("s6_no_pulse_after_rst", 32'(start_cnt), 32'(snap));
    check("s6_post_rst_speed", 32'(core_if.speed), 32'd0);
    check("s6_post_rst_dir", 32'(core_if.dir), 32'(DIR_RIGHT));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/snake_input_conditioner.md
Name: snake_input_conditioner

Overview:
Front-end stage feeding the snake game core. It conditions the raw board inputs: four direction buttons, the start button, and the rotary encoder A/B/push. It outputs a reversal-filtered direction, a one-cycle start pulse, a speed level 0-3, and the one-cycle game step tick that drives the control FSM. It replaces the ad-hoc async edge logic with a single synchronous clk domain.

Parameters:
DEB_CYCLES, 1000000, button debounce stability window in clk cycles (10 ms at 100 MHz)
ENC_DEB_CYCLES, 50000, encoder A/B/SW debounce window in clk cycles
TICK_DIV0, 50000000, step period in clk cycles at speed 0
TICK_DIV1, 40000000, step period at speed 1
TICK_DIV2, 20000000, step period at speed 2
TICK_DIV3, 10000000, step period at speed 3

Ports:
clk  in  1  system clock, 100 MHz
clrn  in  1  reset, asynchronous, active-low
btn_up/btn_down/btn_left/btn_right  in  1 each  raw buttons, active-high, asynchronous
btn_start  in  1  raw start/confirm button, active-high
enc_a, enc_b  in  1 each  raw encoder quadrature
enc_sw  in  1  raw encoder push, active-low
run  in  1  synchronous tick enable from the game core (high while playing)
new_game  in  1  synchronous 1-cycle pulse at game init
dir  out  2  committed direction: 00 up, 01 down, 10 left, 11 right
game_tick  out  1  1-cycle step strobe
start_pulse  out  1  1-cycle pulse on debounced start press
speed  out  2  current speed level

Behaviour:
- Reset is asynchronous, active-low, on clrn. The clock is clk.
- Reset values: dir=11, pending=11, game_tick=0, start_pulse=0, speed=0, tick counter=0. Synchronizer/stable state is 0 for buttons and enc_a/enc_b, and 1 for enc_sw.
- Each raw input passes through a 2-FF synchronizer, then a debouncer. The stable value flips only after the synced value has differed from it for N consecutive cycles. Any match clears the counter.
- Button rising edge (stable 0->1) produces a registered 1-cycle pulse. Latency from raw to pulse is DEB_CYCLES+3 clk, with ±1 for async sampling.
- Simultaneous direction pulses use priority up>down>left>right. Only the winner is considered.
- Reversal filter: a request is a reversal when req[1]==ref[1] and req[0]!=ref[0]. ref is the value dir holds after the current edge, i.e. pending if game_tick fires this cycle, otherwise dir. A reversal request is dropped. Any other request, including one equal to ref, is written to pending.
- Commit: on the edge that sets game_tick=1, dir<=pending. dir and game_tick are valid in the same cycle. A request arriving in the tick cycle lands in pending and commits on the next tick.
- Encoder: on rising edge of debounced A, if debounced B==0 then speed+1, saturating at 3; otherwise speed-1, saturating at 0. A debounced enc_sw falling edge forces speed=0 and beats a same-cycle step.
- Tick generator:
  - period = TICK_DIVn selected by speed.
  - The counter counts 0..period-1. At period-1 it issues game_tick and wraps to 0.
  - The counter is cleared, with no tick, whenever speed changes, run=0, or new_game=1.
  - While run=0, game_tick stays 0.
- new_game: dir<=11, pending<=11, counter<=0. It beats a same-cycle button pulse and tick. speed is unaffected.
- start_pulse is independent of run.
- Reset mid-debounce discards all partial counts.
- All counters are sized for their maximum parameter: 26 bits for the tick counter, ceil(log2(DEB_CYCLES+1)) for the debounce counters. There is no overflow wrap.

Decomposition:
- snake_pkg holds the direction constants DIR_UP=00, DIR_DOWN=01, DIR_LEFT=10, DIR_RIGHT=11, and DIR_RESET=DIR_RIGHT.
- snake_pkg also holds the speed width constant (2) and a reversal-check function.
- One sub-module, debounce_cell, with parameters CYCLES and RESET_VAL. It contains the 2-FF sync, stability counter and stable output, and produces rise/fall pulses. It is instantiated 8 times: 5 at DEB_CYCLES, 3 at ENC_DEB_CYCLES.

Test Plan:
Bench parameters for all scenarios: DEB_CYCLES=4, ENC_DEB_CYCLES=2, TICK_DIV0..3=40,32,16,8.
1. Bounce: btn_up toggles every 2 clk for 20 clk, then held high. Required: no pulse during the toggling; exactly one pulse 7±1 clk after the final rise; pending=00.
2. Reversal: dir=11 (after reset); press left. Required: pending stays 11, and dir=11 after the next tick. Then press up, tick, then press down. Required: dir=00 and pending remains 00.
3. Tick rate: run=1, speed 0. Required: game_tick every 40 clk. Three CW detents (A rises with B=0) give speed=3 and ticks every 8 clk. A fourth CW detent keeps speed=3. Each speed change restarts the 8/16/32 count from 0.
4. Coincidence: a right-press pulse lands in the same cycle as a tick while pending=00 and dir=11. Required: dir=00 at that tick. The request is checked against 00, is not a reversal, enters pending, and commits dir=11 at the following tick.
5. Encoder push while speed=2: enc_sw low for more than 4 clk. Required: speed=0. A same-cycle CW edge is ignored.
6. new_game with pending=10 mid-count. Required: dir=11, pending=11, next tick exactly TICK_DIVn clk later. Repeat with clrn asserted mid-debounce. Required: all outputs return to reset values asynchronously and no pulse follows release.
